// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the VGA raster generator and the helper
//   that sizes its counters.
//   - SVGA_* : 800x600@60, 40 MHz pixel clock from a 240 MHz source (CLK_DIV 6)
//   - VGA_*  : 640x480@60, 25 MHz pixel clock from a 100 MHz source (CLK_DIV 4)
//   - cnt_width(total): bits needed to hold 0..total-1 (never less than 1)
package vga_timing_pkg;

  localparam int unsigned SVGA_CLK_DIV   = 6;
  localparam int unsigned SVGA_H_VISIBLE = 800;
  localparam int unsigned SVGA_H_FP      = 40;
  localparam int unsigned SVGA_H_SYNC    = 128;
  localparam int unsigned SVGA_H_BP      = 88;
  localparam int unsigned SVGA_V_VISIBLE = 600;
  localparam int unsigned SVGA_V_FP      = 1;
  localparam int unsigned SVGA_V_SYNC    = 4;
  localparam int unsigned SVGA_V_BP      = 23;
  localparam bit          SVGA_HSYNC_POL = 1'b1;
  localparam bit          SVGA_VSYNC_POL = 1'b1;

  localparam int unsigned VGA_CLK_DIV    = 4;
  localparam int unsigned VGA_H_VISIBLE  = 640;
  localparam int unsigned VGA_H_FP       = 16;
  localparam int unsigned VGA_H_SYNC     = 96;
  localparam int unsigned VGA_H_BP       = 48;
  localparam int unsigned VGA_V_VISIBLE  = 480;
  localparam int unsigned VGA_V_FP       = 10;
  localparam int unsigned VGA_V_SYNC     = 2;
  localparam int unsigned VGA_V_BP       = 33;
  localparam bit          VGA_HSYNC_POL  = 1'b0;
  localparam bit          VGA_VSYNC_POL  = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned total);
    int unsigned w;
    w = (total <= 2) ? 1 : $clog2(total);
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal or vertical): a position counter running
//   through visible, front porch, sync and back porch regions, with the sync
//   level and the active flag registered alongside the count so they always
//   describe the current count.
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset; count parks at TOTAL-1
//   adv    in   advance strobe (one position per asserted clk edge)
//   count  out  current position, 0..TOTAL-1
//   sync   out  POL while count is inside the sync region, ~POL otherwise
//   active out  1 while count < VISIBLE
//   wrap   out  combinational: adv && count==TOTAL-1 (count returns to 0 this edge)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 800,
  parameter int unsigned FP      = 40,
  parameter int unsigned SYNC    = 128,
  parameter int unsigned BP      = 88,
  parameter bit          POL     = 1'b1,
  localparam int unsigned TOTAL  = VISIBLE + FP + SYNC + BP,
  localparam int unsigned W      = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);

  if (FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_axis
    $error("vga_axis_counter: FP, SYNC and BP must all be at least 1");
  end

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_BEGIN = W'(VISIBLE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(VISIBLE + FP + SYNC);

  logic [W-1:0] count_nxt;

  assign wrap = adv && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (adv) begin
      count_nxt = wrap ? '0 : count + W'(1);
    end
  end

  // sync/active are derived from the next count so they change on the same
  // edge as the count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= LAST;
      sync   <= ~POL;
      active <= 1'b0;
    end else if (adv) begin
      count  <= count_nxt;
      sync   <= ((count_nxt >= SYNC_BEGIN) && (count_nxt < SYNC_END)) ? POL : ~POL;
      active <= (count_nxt < VIS_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator. A clock divider produces one advance edge
//   every CLK_DIV clk cycles; the horizontal axis counter steps on that edge
//   and the vertical one steps on the horizontal wrap.
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pix_en       out  high for the one clk cycle after each advance edge
//   hsync        out  horizontal sync, level HSYNC_POL while asserted
//   vsync        out  vertical sync, level VSYNC_POL while asserted
//   visible      out  1 while (x,y) is inside the visible area
//   x            out  horizontal position 0..H_TOTAL-1
//   y            out  vertical position 0..V_TOTAL-1
//   line_start   out  pix_en && x==0
//   frame_start  out  pix_en && x==0 && y==0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = SVGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = SVGA_H_VISIBLE,
  parameter int unsigned H_FP      = SVGA_H_FP,
  parameter int unsigned H_SYNC    = SVGA_H_SYNC,
  parameter int unsigned H_BP      = SVGA_H_BP,
  parameter int unsigned V_VISIBLE = SVGA_V_VISIBLE,
  parameter int unsigned V_FP      = SVGA_V_FP,
  parameter int unsigned V_SYNC    = SVGA_V_SYNC,
  parameter int unsigned V_BP      = SVGA_V_BP,
  parameter bit          HSYNC_POL = SVGA_HSYNC_POL,
  parameter bit          VSYNC_POL = SVGA_VSYNC_POL,
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW       = cnt_width(H_TOTAL),
  localparam int unsigned VW       = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  if (CLK_DIV == 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam int unsigned    TW        = cnt_width(CLK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_DIV - 1);

  logic [TW-1:0] tick;
  logic          adv;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_active;
  logic          v_active;

  // With CLK_DIV==1 TICK_LAST is 0 and tick never leaves 0, so every edge advances.
  assign adv = (tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick        <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick        <= adv ? '0 : tick + TW'(1);
      pix_en      <= adv;
      // h_wrap/v_wrap already include adv and mark the edge that lands on 0.
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (HSYNC_POL)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .count  (x),
    .sync   (hsync),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (VSYNC_POL)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .count  (y),
    .sync   (vsync),
    .active (v_active),
    .wrap   (v_wrap)
  );

  // Both terms are flops loaded on the same advance edge as x and y, so
  // visible changes exactly together with the coordinates.
  assign visible = h_active && v_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    int d;
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    logic pe; logic ls; logic fs; logic hs; logic vs; logic vis;
    int x; int y;
  } exp_t;

  typedef struct {
    int n;
    int x; int y;
    bit hs; bit vs; bit vis; bit pe; bit ls; bit fs;
  } vec_t;

  localparam cfg_t CFG_A = '{d:3, hv:10, hf:2, hs:3, hb:2, vv:6, vf:1, vs:2, vb:1, hp:1'b1, vp:1'b0};
  localparam cfg_t CFG_B = '{d:1, hv:4, hf:1, hs:2, hb:1, vv:3, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_pe, a_hs, a_vs, a_vis, a_ls, a_fs;
  logic [4:0] a_x;
  logic [3:0] a_y;
  logic       b_pe, b_hs, b_vs, b_vis, b_ls, b_fs;
  logic [2:0] b_x;
  logic [2:0] b_y;

  int checks = 0;
  int errors = 0;
  int k_a = 0;
  int k_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(a_pe), .hsync(a_hs), .vsync(a_vs), .visible(a_vis),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(b_pe), .hsync(b_hs), .vsync(b_vs), .visible(b_vis),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  // Reference: k clk edges since reset released -> k/d pixels have elapsed;
  // the first pixel lands on raster position 0 and positions run linearly
  // through the frame.
  function automatic exp_t model(input cfg_t c, input int k);
    exp_t m;
    int ht, vt, a, p;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    a  = k / c.d;
    if (a == 0) begin
      m.x = ht - 1;
      m.y = vt - 1;
    end else begin
      p   = (a - 1) % (ht * vt);
      m.x = p % ht;
      m.y = p / ht;
    end
    m.pe  = (k > 0) && (k % c.d == 0);
    m.ls  = m.pe && (m.x == 0);
    m.fs  = m.ls && (m.y == 0);
    m.hs  = (m.x >= c.hv + c.hf && m.x < c.hv + c.hf + c.hs) ? c.hp : !c.hp;
    m.vs  = (m.y >= c.vv + c.vf && m.y < c.vv + c.vf + c.vs) ? c.vp : !c.vp;
    m.vis = (a > 0) && (m.x < c.hv) && (m.y < c.vv);
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k_a = rst ? 0 : k_a + 1;
    k_b = rst ? 0 : k_b + 1;
    #1;
  endtask

  task automatic check_a(input string tag);
    exp_t e;
    e = model(CFG_A, k_a);
    chk({tag, ".a.x"}, int'(a_x), e.x);
    chk({tag, ".a.y"}, int'(a_y), e.y);
    chk({tag, ".a.pix_en"}, int'(a_pe), int'(e.pe));
    chk({tag, ".a.line_start"}, int'(a_ls), int'(e.ls));
    chk({tag, ".a.frame_start"}, int'(a_fs), int'(e.fs));
    chk({tag, ".a.hsync"}, int'(a_hs), int'(e.hs));
    chk({tag, ".a.vsync"}, int'(a_vs), int'(e.vs));
    chk({tag, ".a.visible"}, int'(a_vis), int'(e.vis));
  endtask

  task automatic check_b(input string tag);
    exp_t e;
    e = model(CFG_B, k_b);
    chk({tag, ".b.x"}, int'(b_x), e.x);
    chk({tag, ".b.y"}, int'(b_y), e.y);
    chk({tag, ".b.pix_en"}, int'(b_pe), int'(e.pe));
    chk({tag, ".b.line_start"}, int'(b_ls), int'(e.ls));
    chk({tag, ".b.frame_start"}, int'(b_fs), int'(e.fs));
    chk({tag, ".b.hsync"}, int'(b_hs), int'(e.hs));
    chk({tag, ".b.vsync"}, int'(b_vs), int'(e.vs));
    chk({tag, ".b.visible"}, int'(b_vis), int'(e.vis));
  endtask

  task automatic check_vec_a(input string tag, input vec_t v);
    chk({tag, ".x"}, int'(a_x), v.x);
    chk({tag, ".y"}, int'(a_y), v.y);
    chk({tag, ".hsync"}, int'(a_hs), int'(v.hs));
    chk({tag, ".vsync"}, int'(a_vs), int'(v.vs));
    chk({tag, ".visible"}, int'(a_vis), int'(v.vis));
    chk({tag, ".pix_en"}, int'(a_pe), int'(v.pe));
    chk({tag, ".line_start"}, int'(a_ls), int'(v.ls));
    chk({tag, ".frame_start"}, int'(a_fs), int'(v.fs));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    int hold;

    // Instance A: CLK_DIV 3, H 10/2/3/2 (total 17, hsync active-high at 12..14),
    // V 6/1/2/1 (total 10, vsync active-low at 7..8). n = clk edges after release.
    //            n    x   y  hs vs vis pe ls fs
    vecs[0]  = '{  0, 16,  9, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{  1, 16,  9, 0, 1, 0, 0, 0, 0};
    vecs[2]  = '{  2, 16,  9, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{  3,  0,  0, 0, 1, 1, 1, 1, 1};
    vecs[4]  = '{  4,  0,  0, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{  6,  1,  0, 0, 1, 1, 1, 0, 0};
    vecs[6]  = '{ 39, 12,  0, 1, 1, 0, 1, 0, 0};
    vecs[7]  = '{ 45, 14,  0, 1, 1, 0, 1, 0, 0};
    vecs[8]  = '{ 48, 15,  0, 0, 1, 0, 1, 0, 0};
    vecs[9]  = '{ 54,  0,  1, 0, 1, 1, 1, 1, 0};
    vecs[10] = '{360,  0,  7, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{510, 16,  9, 0, 1, 0, 1, 0, 0};
    vecs[12] = '{513,  0,  0, 0, 1, 1, 1, 1, 1};

    do_reset(2);
    foreach (vecs[i]) begin
      while (k_a < vecs[i].n) step();
      check_vec_a($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-pixel reset at (5,2), tick 1.
    do_reset(1);
    while (k_a < 121) step();
    chk("midrst.pre.x", int'(a_x), 5);
    chk("midrst.pre.y", int'(a_y), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.x", int'(a_x), 16);
    chk("midrst.y", int'(a_y), 9);
    chk("midrst.hsync", int'(a_hs), 0);
    chk("midrst.vsync", int'(a_vs), 1);
    chk("midrst.visible", int'(a_vis), 0);
    chk("midrst.pix_en", int'(a_pe), 0);
    step();
    step();
    chk("midrst.wait.pix_en", int'(a_pe), 0);
    chk("midrst.wait.x", int'(a_x), 16);
    step();
    chk("midrst.resume.frame_start", int'(a_fs), 1);
    chk("midrst.resume.x", int'(a_x), 0);
    chk("midrst.resume.y", int'(a_y), 0);

    // Instance B: CLK_DIV 1, active-low syncs, frame of 8x6 pixels.
    do_reset(1);
    chk("b.rst.pix_en", int'(b_pe), 0);
    for (int i = 1; i <= 49; i++) begin
      step();
      chk("b.pix_en_const", int'(b_pe), 1);
      if (k_b == 1 || k_b == 49) begin
        chk("b.wrap.x", int'(b_x), 0);
        chk("b.wrap.y", int'(b_y), 0);
        chk("b.wrap.frame_start", int'(b_fs), 1);
      end
      if (k_b == 48) begin
        chk("b.last.x", int'(b_x), 7);
        chk("b.last.y", int'(b_y), 5);
        chk("b.last.frame_start", int'(b_fs), 0);
      end
      if (k_b == 6 || k_b == 7) chk("b.hsync_low", int'(b_hs), 0);
      if (k_b == 5 || k_b == 8) chk("b.hsync_high", int'(b_hs), 1);
      if (k_b == 33) chk("b.vsync_low", int'(b_vs), 0);
      if (k_b == 25 || k_b == 41) chk("b.vsync_high", int'(b_vs), 1);
    end

    // Random run with sporadic resets, both instances against the model.
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst  = 1'b1;
        hold = $urandom_range(1, 3);
      end
      step();
      check_a("rnd");
      check_b("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
